priority_queue: RTL and testbench

Hardware min-priority queue holding up to DEPTH data/ID entries, kept sorted in a register array with the smallest data value at the head.
- Supports push, pop (removes the head) and drop (removes by ID).
- Exposes the head through a combinational peek port.
- When full, a push evicts the lowest-priority entry through an overflow port.
- Used as a scheduling/ordering primitive next to a request source.

---
 rtl/priority_queue.sv | 199 +++++++++++++++++++
 tb/tb_priority_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_queue.sv
// -----------------------------------------------------------------------------
// priority_queue
//   Min-priority queue of up to DEPTH {data, id} entries kept sorted in a
//   register array. Entry 0 is the head (smallest data). Equal data values
//   keep arrival order. A push into a full queue evicts the tail of the
//   combined sorted set through the overflow port.
//
// Ports:
//   clk_i            clock, all state changes on rising edge
//   rst_i            synchronous active-high reset
//   push_i, data_i   push request and its data
//   pop_i            pop request (removes head)
//   drop_i, drop_id_i  drop request and the ID to remove
//   push_id_o        ID assigned to the next accepted push
//   push_rdy_o / pop_rdy_o / drop_rdy_o  combinational accept indications
//   full_o, empty_o, cnt_o  occupancy status
//   data_o           data of the last popped entry (registered)
//   peek_vld_o, peek_data_o  combinational head view
//   overflow_o       one-cycle pulse when a push evicted an entry
//   data_overflow_o  evicted data, held until the next overflow
// -----------------------------------------------------------------------------
module priority_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int IW    = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          drop_i,
  input  logic [IW-1:0] drop_id_i,
  input  logic [DW-1:0] data_i,
  output logic [IW-1:0] push_id_o,
  output logic          push_rdy_o,
  output logic          pop_rdy_o,
  output logic          drop_rdy_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o,
  output logic [DW-1:0] data_o,
  output logic          peek_vld_o,
  output logic [DW-1:0] peek_data_o,
  output logic          overflow_o,
  output logic [DW-1:0] data_overflow_o
);

  // Storage
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [IW-1:0] id_q   [DEPTH];
  logic [IW-1:0] id_d   [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] push_id_q, push_id_d;
  logic [DW-1:0] pop_data_q, pop_data_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] ovf_data_q, ovf_data_d;

  // Per-slot helper signals
  logic [DEPTH-1:0] valid;     // slot holds a live entry
  logic [DEPTH-1:0] le;        // live entry that sorts ahead of data_i
  logic [DEPTH-1:0] match;     // live entry whose ID equals drop_id_i
  logic [DEPTH-1:0] hit_pre;   // a match exists at this slot or nearer the head
  logic [DEPTH-1:0] ins_at;    // data_i is inserted exactly at this slot
  logic [DW-1:0]    prev_data [DEPTH];
  logic [IW-1:0]    prev_id   [DEPTH];
  logic [DW-1:0]    next_data [DEPTH];
  logic [IW-1:0]    next_id   [DEPTH];

  logic full, empty;
  logic pop_acc, push_acc, drop_acc;
  logic [DW-1:0] evict_data;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // pop > push > drop; only one operation is accepted per cycle
  assign pop_acc  = pop_i && !empty;
  assign push_acc = push_i && !pop_acc;
  assign drop_acc = drop_i && !pop_acc && !push_i;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign valid[gi]   = (CW'(gi) < cnt_q);
      // '<=' places a new item behind equal-valued ones, preserving arrival order
      assign le[gi]      = valid[gi] && (data_q[gi] <= data_i);
      assign match[gi]   = valid[gi] && (id_q[gi] == drop_id_i);
      assign hit_pre[gi] = |match[gi:0];

      // le is a thermometer code (array is sorted and valid entries are
      // contiguous), so the insert point is its first zero
      if (gi == 0) begin : g_head
        assign ins_at[gi]    = !le[gi];
        assign prev_data[gi] = data_i;
        assign prev_id[gi]   = push_id_q;
      end else begin : g_body
        assign ins_at[gi]    = !le[gi] && le[gi-1];
        assign prev_data[gi] = data_q[gi-1];
        assign prev_id[gi]   = id_q[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_tail
        assign next_data[gi] = data_q[gi];
        assign next_id[gi]   = id_q[gi];
      end else begin : g_mid
        assign next_data[gi] = data_q[gi+1];
        assign next_id[gi]   = id_q[gi+1];
      end
    end
  endgenerate

  // When full, the tail of the combined set is lost: either data_i itself
  // (it sorts behind every entry) or the current last entry
  assign evict_data = le[DEPTH-1] ? data_i : data_q[DEPTH-1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
      id_d[i]   = id_q[i];
      if (pop_acc) begin
        data_d[i] = next_data[i];
        id_d[i]   = next_id[i];
      end else if (push_acc) begin
        if (ins_at[i]) begin
          data_d[i] = data_i;
          id_d[i]   = push_id_q;
        end else if (!le[i]) begin
          data_d[i] = prev_data[i];
          id_d[i]   = prev_id[i];
        end
      end else if (drop_acc && hit_pre[i]) begin
        data_d[i] = next_data[i];
        id_d[i]   = next_id[i];
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    push_id_d  = push_id_q;
    pop_data_d = pop_data_q;
    ovf_d      = 1'b0;
    ovf_data_d = ovf_data_q;
    if (pop_acc) begin
      cnt_d      = cnt_q - CW'(1);
      pop_data_d = data_q[0];
    end else if (push_acc) begin
      push_id_d = push_id_q + IW'(1);
      if (full) begin
        ovf_d      = 1'b1;
        ovf_data_d = evict_data;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (drop_acc && hit_pre[DEPTH-1]) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      cnt_q      <= '0;
      push_id_q  <= '0;
      pop_data_q <= '0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        id_q[i]   <= id_d[i];
      end
      cnt_q      <= cnt_d;
      push_id_q  <= push_id_d;
      pop_data_q <= pop_data_d;
      ovf_q      <= ovf_d;
      ovf_data_q <= ovf_data_d;
    end
  end

  assign push_id_o       = push_id_q;
  assign pop_rdy_o       = !empty;
  assign push_rdy_o      = !pop_acc;
  assign drop_rdy_o      = !pop_acc && !push_i;
  assign full_o          = full;
  assign empty_o         = empty;
  assign cnt_o           = cnt_q;
  assign data_o          = pop_data_q;
  assign peek_vld_o      = !empty;
  assign peek_data_o     = empty ? '0 : data_q[0];
  assign overflow_o      = ovf_q;
  assign data_overflow_o = ovf_data_q;

endmodule

// File: tb/tb_priority_queue.sv
module tb_priority_queue;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int IW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          push_i = 1'b0, pop_i = 1'b0, drop_i = 1'b0;
  logic [IW-1:0] drop_id_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [IW-1:0] push_id_o;
  logic          push_rdy_o, pop_rdy_o, drop_rdy_o, full_o, empty_o;
  logic [CW-1:0] cnt_o;
  logic [DW-1:0] data_o, peek_data_o, data_overflow_o;
  logic          peek_vld_o, overflow_o;

  priority_queue #(.DEPTH(DEPTH), .DW(DW), .IW(IW), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .pop_i(pop_i),
    .drop_i(drop_i), .drop_id_i(drop_id_i), .data_i(data_i),
    .push_id_o(push_id_o), .push_rdy_o(push_rdy_o), .pop_rdy_o(pop_rdy_o),
    .drop_rdy_o(drop_rdy_o), .full_o(full_o), .empty_o(empty_o),
    .cnt_o(cnt_o), .data_o(data_o), .peek_vld_o(peek_vld_o),
    .peek_data_o(peek_data_o), .overflow_o(overflow_o),
    .data_overflow_o(data_overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } entry_t;

  // Reference model: a sorted queue of entries plus the visible registers
  entry_t        q[$];
  logic [IW-1:0] m_push_id = '0;
  logic [DW-1:0] m_data_o = '0;
  logic          m_ovf = 1'b0;
  logic [DW-1:0] m_ovf_data = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    logic [DW-1:0] head;
    head = (q.size() == 0) ? '0 : q[0].data;
    chk("cnt",       32'(cnt_o),           32'(q.size()));
    chk("empty",     32'(empty_o),         32'(q.size() == 0));
    chk("full",      32'(full_o),          32'(q.size() == DEPTH));
    chk("peek_vld",  32'(peek_vld_o),      32'(q.size() != 0));
    chk("peek_data", 32'(peek_data_o),     32'(head));
    chk("push_id",   32'(push_id_o),       32'(m_push_id));
    chk("data_o",    32'(data_o),          32'(m_data_o));
    chk("overflow",  32'(overflow_o),      32'(m_ovf));
    chk("ovf_data",  32'(data_overflow_o), 32'(m_ovf_data));
  endtask

  // One clock cycle with the given requests; checks readies before the
  // edge and the whole visible state after it.
  task automatic step(input bit pu, input bit po, input bit dr,
                      input logic [IW-1:0] did, input logic [DW-1:0] dat);
    bit pop_ok, push_ok, drop_ok;
    int k;
    entry_t e;
    push_i = pu; pop_i = po; drop_i = dr; drop_id_i = did; data_i = dat;
    #1;
    pop_ok  = po && (q.size() != 0);
    push_ok = pu && !pop_ok;
    drop_ok = dr && !pop_ok && !pu;
    chk("pop_rdy",  32'(pop_rdy_o),  32'(q.size() != 0));
    chk("push_rdy", 32'(push_rdy_o), 32'(!(po && q.size() != 0)));
    chk("drop_rdy", 32'(drop_rdy_o), 32'(!(po && q.size() != 0) && !pu));
    @(posedge clk);
    m_ovf = 1'b0;
    if (pop_ok) begin
      m_data_o = q[0].data;
      void'(q.pop_front());
    end else if (push_ok) begin
      e.data = dat; e.id = m_push_id;
      k = 0;
      while (k < q.size() && q[k].data <= dat) k++;
      q.insert(k, e);
      if (q.size() > DEPTH) begin
        m_ovf = 1'b1;
        m_ovf_data = q[q.size()-1].data;
        void'(q.pop_back());
      end
      m_push_id = m_push_id + 1'b1;
    end else if (drop_ok) begin
      for (int j = 0; j < q.size(); j++) begin
        if (q[j].id == did) begin
          q.delete(j);
          break;
        end
      end
    end
    #1;
    push_i = 0; pop_i = 0; drop_i = 0;
    $display("step push=%0b pop=%0b drop=%0b id=%0h data=%0h -> cnt=%0d head=%0h data_o=%0h ovf=%0b",
             pu, po, dr, did, dat, cnt_o, peek_data_o, data_o, overflow_o);
    chk_state();
  endtask

  task automatic do_reset(input bit with_push);
    rst_i = 1; push_i = with_push; data_i = 8'h42;
    @(posedge clk);
    #1;
    rst_i = 0; push_i = 0;
    q.delete();
    m_push_id = '0; m_data_o = '0; m_ovf = 1'b0; m_ovf_data = '0;
    $display("reset -> cnt=%0d push_id=%0h data_o=%0h", cnt_o, push_id_o, data_o);
    chk_state();
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(1'b1);

    // Basic ordering and IDs
    step(1, 0, 0, 0, 8'hF0);
    step(1, 0, 0, 0, 8'h15);
    step(1, 0, 0, 0, 8'h87);
    chk("tp1_cnt", 32'(cnt_o), 3);
    chk("tp1_peek", 32'(peek_data_o), 32'h15);
    chk("tp1_id", 32'(push_id_o), 3);
    step(0, 1, 0, 0, 0); chk("tp1_pop0", 32'(data_o), 32'h15);
    step(0, 1, 0, 0, 0); chk("tp1_pop1", 32'(data_o), 32'h87);
    step(0, 1, 0, 0, 0); chk("tp1_pop2", 32'(data_o), 32'hF0);
    chk("tp1_empty", 32'(empty_o), 1);
    chk("tp1_poprdy", 32'(pop_rdy_o), 0);
    step(0, 1, 0, 0, 0);  // pop on empty: ignored

    // Drop by ID
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'hEB);
    step(1, 0, 0, 0, 8'hAF);
    step(0, 1, 0, 0, 0); chk("tp2_pop", 32'(data_o), 32'h01);
    step(0, 0, 1, 8'd3, 0); chk("tp2_drop3", 32'(cnt_o), 2);
    step(0, 0, 1, 8'd5, 0); chk("tp2_drop5", 32'(cnt_o), 1);
    step(0, 1, 0, 0, 0); chk("tp2_pop2", 32'(data_o), 32'hEB);

    // Interleaved push/pop
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h12);
    step(0, 1, 0, 0, 0); chk("tp3_pop", 32'(data_o), 32'h01);
    step(1, 0, 0, 0, 8'h13);
    chk("tp3_peek", 32'(peek_data_o), 32'h11);
    chk("tp3_cnt", 32'(cnt_o), 3);

    // Overflow
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
    step(1, 0, 0, 0, 8'h05);
    chk("tp4_ovf", 32'(overflow_o), 1);
    chk("tp4_ovfd", 32'(data_overflow_o), 32'h17);
    chk("tp4_head", 32'(peek_data_o), 32'h05);
    step(0, 0, 0, 0, 0);
    chk("tp4_pulse", 32'(overflow_o), 0);
    chk("tp4_hold", 32'(data_overflow_o), 32'h17);
    step(1, 0, 0, 0, 8'hFF);
    chk("tp4_ovff", 32'(data_overflow_o), 32'hFF);
    chk("tp4_cnt", 32'(cnt_o), DEPTH);

    // Pop beats push; equal data keeps arrival order
    step(1, 1, 0, 0, 8'h00);
    chk("tp5_cnt", 32'(cnt_o), DEPTH - 1);
    do_reset(1'b0);
    step(1, 0, 0, 0, 8'h20);      // id 0
    step(1, 0, 0, 0, 8'h20);      // id 1
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 8'd0, 0);       // id 0 already popped: no effect
    chk("tp5_order", 32'(cnt_o), 1);
    step(0, 0, 1, 8'd1, 0);
    chk("tp5_drop1", 32'(cnt_o), 0);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h30 - i));
    step(0, 1, 0, 0, 0);
    do_reset(1'b1);
    chk("tp6_cnt", 32'(cnt_o), 0);
    chk("tp6_id", 32'(push_id_o), 0);
    chk("tp6_data", 32'(data_o), 0);

    // Randomized traffic with a narrow data range to exercise ties
    for (int n = 0; n < 800; n++) begin
      int r;
      bit pu, po, dr;
      logic [IW-1:0] did;
      logic [DW-1:0] dat;
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        r   = $urandom_range(0, 99);
        pu  = r < 55;
        po  = $urandom_range(0, 99) < 35;
        dr  = $urandom_range(0, 99) < 40;
        did = m_push_id - IW'($urandom_range(1, 10));
        dat = DW'($urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) dat = DW'($urandom_range(0, 255));
        step(pu, po, dr, did, dat);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
